// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   PC_W            program-counter / ROM address width
//   INSTR_W         instruction word width
//   DEF_STACK_DEPTH default return-stack depth (power of two)
//   fsm_state_t     fetch controller state encoding
package fetch_pkg;

  localparam int unsigned PC_W            = 11;
  localparam int unsigned INSTR_W         = 14;
  localparam int unsigned DEF_STACK_DEPTH = 8;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, its program ROM and the
// execute stage.
//   rom_addr/rom_data             combinational program-memory port
//   stall/jump/call/ret/skip      flow-control requests from execute
//   target                        jump/call destination
//   ir/ir_valid/ir_pc             fetched instruction and its address
//   stk_ovf/stk_unf               sticky return-stack error flags
// modport master: the fetch controller; modport slave: its environment.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               stall;
  logic               jump;
  logic               call;
  logic               ret;
  logic               skip;
  logic [PC_W-1:0]    target;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic [PC_W-1:0]    ir_pc;
  logic               stk_ovf;
  logic               stk_unf;

  modport master (
    output rom_addr, ir, ir_valid, ir_pc, stk_ovf, stk_unf,
    input  rom_data, stall, jump, call, ret, skip, target
  );

  modport slave (
    input  rom_addr, ir, ir_valid, ir_pc, stk_ovf, stk_unf,
    output rom_data, stall, jump, call, ret, skip, target
  );

endinterface

// File: rtl/return_stack.sv
// Circular return-address stack.
//   clk, rst_n  clock / async active-low reset (storage itself is not reset)
//   push        write push_addr at sp, advance sp
//   pop         retreat sp; top presents the entry being popped
//   push_addr   return address to store
//   top         entry at sp-1 (combinational)
//   ovf, unf    sticky overflow / underflow flags, cleared only by reset
// push and pop must not be asserted together.
module return_stack
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_STACK_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_addr,
  output logic [PC_W-1:0] top,
  output logic            ovf,
  output logic            unf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_dec;
  logic [PTR_W:0]   count;

  // DEPTH is a power of two, so the pointer wraps by natural overflow.
  assign sp_dec = sp - 1'b1;
  assign top    = mem[sp_dec];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[sp] <= push_addr;
    end
  end

  // Occupancy saturates at DEPTH on overflow and at zero on underflow; the
  // pointer keeps moving so the oldest entry is overwritten / re-read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= sp + 1'b1;
      if (count == FULL) begin
        ovf <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end else if (pop) begin
      sp <= sp_dec;
      if (count == '0) begin
        unf <= 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the PC, the instruction register and
// the BOOT/RUN sequencer; return addresses live in return_stack.
//   clk, rst_n  clock / async active-low reset
//   bus         fetch_controller_if.master (ROM port, flow control, IR out)
// Redirect priority when not stalled: ret > call > jump > skip. Every
// redirect or skip turns the word fetched in that cycle into a bubble.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 11'h000,
  parameter int unsigned     STACK_DEPTH  = DEF_STACK_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  fetch_controller_if.master bus
);

  fsm_state_t      state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] ret_addr;
  logic            fetch_en;
  logic            do_ret;
  logic            do_call;
  logic            do_jump;
  logic            do_skip;

  assign bus.rom_addr = pc;
  assign pc_inc       = pc + 1'b1;

  assign fetch_en = (state == RUN) && !bus.stall;
  assign do_ret   = fetch_en && bus.ret;
  assign do_call  = fetch_en && bus.call && !bus.ret;
  assign do_jump  = fetch_en && bus.jump && !bus.ret && !bus.call;
  assign do_skip  = fetch_en && bus.skip && !bus.ret && !bus.call && !bus.jump;

  always_comb begin
    pc_next = pc_inc;
    if (do_ret) begin
      pc_next = ret_addr;
    end else if (do_call || do_jump) begin
      pc_next = bus.target;
    end
  end

  return_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (do_call),
    .pop      (do_ret),
    .push_addr(pc),
    .top      (ret_addr),
    .ovf      (bus.stk_ovf),
    .unf      (bus.stk_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      bus.ir       <= '0;
      bus.ir_pc    <= '0;
      bus.ir_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (fetch_en) begin
            bus.ir       <= bus.rom_data;
            bus.ir_pc    <= pc;
            bus.ir_valid <= !(do_ret || do_call || do_jump || do_skip);
            pc           <= pc_next;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fetch_controller_if bus ();

  fetch_controller #(
    .RESET_VECTOR(11'h000),
    .STACK_DEPTH (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ROM model: word = 14'h3E00 | address
  assign bus.rom_data = 14'h3E00 | {3'b000, bus.rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [10:0] pc_e, input logic v_e);
    chk({tag, "_ir_pc"}, 32'(bus.ir_pc), 32'(pc_e));
    chk({tag, "_valid"}, 32'(bus.ir_valid), 32'(v_e));
    chk({tag, "_ir"}, 32'(bus.ir), 32'(14'h3E00 | {3'b000, pc_e}));
  endtask

  logic [10:0] ret_exp [9];

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.stall  = 1'b0;
    bus.jump   = 1'b0;
    bus.call   = 1'b0;
    bus.ret    = 1'b0;
    bus.skip   = 1'b0;
    bus.target = 11'h000;

    // Reset state
    #12;
    chk("rst_ir", 32'(bus.ir), 32'h0);
    chk("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
    chk("rst_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_ovf", 32'(bus.stk_ovf), 32'h0);
    chk("rst_unf", 32'(bus.stk_unf), 32'h0);
    rst_n = 1'b1;

    // BOOT cycle, then sequential fetch 0,1,2
    tick();
    chk("boot_valid", 32'(bus.ir_valid), 32'h0);
    chk("boot_addr", 32'(bus.rom_addr), 32'h0);
    tick(); chk_ir("seq0", 11'h000, 1'b1);
    tick(); chk_ir("seq1", 11'h001, 1'b1);
    tick(); chk_ir("seq2", 11'h002, 1'b1);
    tick(); chk_ir("seq3", 11'h003, 1'b1);

    // Jump to 0x100 while ir_pc=3
    bus.jump = 1'b1; bus.target = 11'h100;
    tick(); bus.jump = 1'b0;
    chk_ir("jmp_bubble", 11'h004, 1'b0);
    tick(); chk_ir("jmp_tgt", 11'h100, 1'b1);

    // Jump to 4 so that PC=5 when the call is issued
    bus.jump = 1'b1; bus.target = 11'h004;
    tick(); bus.jump = 1'b0;
    tick(); chk_ir("pre_call", 11'h004, 1'b1);
    chk("pre_call_pc", 32'(bus.rom_addr), 32'h005);

    // Call 0x200 from PC=5, return from 0x202
    bus.call = 1'b1; bus.target = 11'h200;
    tick(); bus.call = 1'b0;
    chk_ir("call_bubble", 11'h005, 1'b0);
    tick(); chk_ir("call_200", 11'h200, 1'b1);
    tick(); chk_ir("call_201", 11'h201, 1'b1);
    tick(); chk_ir("call_202", 11'h202, 1'b1);
    bus.ret = 1'b1;
    tick(); bus.ret = 1'b0;
    chk("ret_bubble_valid", 32'(bus.ir_valid), 32'h0);
    tick(); chk_ir("ret_005", 11'h005, 1'b1);
    chk("ret_ovf", 32'(bus.stk_ovf), 32'h0);
    chk("ret_unf", 32'(bus.stk_unf), 32'h0);

    // Stall for 3 cycles with jump asserted: everything held
    bus.stall = 1'b1; bus.jump = 1'b1; bus.target = 11'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ir("stall", 11'h005, 1'b1);
      chk("stall_addr", 32'(bus.rom_addr), 32'h006);
    end
    bus.stall = 1'b0; bus.jump = 1'b0;
    tick(); chk_ir("stall_resume", 11'h006, 1'b1);

    // Skip discards the word at 7
    bus.skip = 1'b1;
    tick(); bus.skip = 1'b0;
    chk_ir("skip_bubble", 11'h007, 1'b0);
    tick(); chk_ir("skip_next", 11'h008, 1'b1);

    // Nine back-to-back calls (PC=9 at the first). Call k (k=1..7) targets
    // 0x400+0x10*k; call 8 targets its own PC (0x470) so the 8th and 9th
    // pushed addresses are both 0x470; call 9 targets 0x500 and also raises
    // jump/skip, which must lose to call.
    for (int k = 1; k <= 7; k++) begin
      bus.call = 1'b1; bus.target = 11'(11'h400 + 11'h10 * k);
      tick();
      chk("ncall_pc", 32'(bus.rom_addr), 32'(11'h400 + 11'h10 * k));
    end
    bus.target = 11'h470;
    tick();
    chk("call8_ovf", 32'(bus.stk_ovf), 32'h0);
    bus.target = 11'h500; bus.jump = 1'b1; bus.skip = 1'b1;
    tick();
    bus.call = 1'b0; bus.jump = 1'b0; bus.skip = 1'b0;
    chk("call9_pc", 32'(bus.rom_addr), 32'h500);
    chk("call9_ovf", 32'(bus.stk_ovf), 32'h1);
    chk("call9_unf", 32'(bus.stk_unf), 32'h0);

    // Nine rets; first one also has call asserted, which must lose to ret.
    ret_exp = '{11'h470, 11'h470, 11'h460, 11'h450, 11'h440,
                11'h430, 11'h420, 11'h410, 11'h470};
    bus.call = 1'b1; bus.target = 11'h555;
    for (int k = 0; k < 9; k++) begin
      bus.ret = 1'b1;
      tick();
      bus.call = 1'b0;
      chk("nret_pc", 32'(bus.rom_addr), 32'(ret_exp[k]));
      if (k == 7) chk("ret8_unf", 32'(bus.stk_unf), 32'h0);
    end
    bus.ret = 1'b0;
    chk("ret9_unf", 32'(bus.stk_unf), 32'h1);
    chk("ret9_ovf", 32'(bus.stk_ovf), 32'h1);

    // PC wrap at 0x7FF
    bus.jump = 1'b1; bus.target = 11'h7FF;
    tick(); bus.jump = 1'b0;
    tick(); chk_ir("wrap_7ff", 11'h7FF, 1'b1);
    chk("wrap_addr", 32'(bus.rom_addr), 32'h000);
    tick(); chk_ir("wrap_000", 11'h000, 1'b1);

    // Reset pulsed while a call is pending; call held through BOOT is ignored
    bus.call = 1'b1; bus.target = 11'h123;
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_ovf", 32'(bus.stk_ovf), 32'h0);
    chk("mid_rst_unf", 32'(bus.stk_unf), 32'h0);
    chk("mid_rst_valid", 32'(bus.ir_valid), 32'h0);
    chk("mid_rst_addr", 32'(bus.rom_addr), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rboot_addr", 32'(bus.rom_addr), 32'h0);
    chk("rboot_valid", 32'(bus.ir_valid), 32'h0);
    bus.call = 1'b0;
    tick(); chk_ir("rst_fetch0", 11'h000, 1'b1);
    chk("rst_fetch_ovf", 32'(bus.stk_ovf), 32'h0);
    tick(); chk_ir("rst_fetch1", 11'h001, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_VECTOR, default 11'h000: PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 8: return-stack entries, power of two.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rom_addr  out  11  program-memory address (drives the ROM address input); equals PC combinationally.
REQ-006 rom_data  in  14  instruction word returned combinationally for rom_addr.
REQ-007 stall  in  1  hold PC, IR, ir_valid and the stack for this cycle.
REQ-008 jump  in  1  redirect PC to target (GOTO).
REQ-009 call  in  1  push return address and redirect PC to target (CALL).
REQ-010 ret  in  1  pop return address into PC (RETURN).
REQ-011 skip  in  1  discard the instruction being fetched this cycle.
REQ-012 target  in  11  jump/call destination.
REQ-013 ir  out  14  instruction register.
REQ-014 ir_valid  out  1  ir holds an instruction to execute.
REQ-015 ir_pc  out  11  address ir was fetched from.
REQ-016 stk_ovf  out  1  sticky stack-overflow flag.
REQ-017 stk_unf  out  1  sticky stack-underflow flag.

Function
REQ-018 FSM states BOOT and RUN; reset enters BOOT; BOOT -> RUN unconditionally on the next edge; no fetch is captured in BOOT.
REQ-019 In RUN with stall=0: ir <= rom_data, ir_pc <= PC, ir_valid <= 1, PC <= PC+1 modulo 2^11 (11'h7FF wraps to 11'h000).
REQ-020 stall=1 holds PC, ir, ir_pc, ir_valid, stack pointer and flags; all control inputs are ignored that cycle.
REQ-021 Redirect priority with stall=0: ret > call > jump > skip; lower-priority requests asserted in the same cycle are ignored.
REQ-022 jump: PC <= target; ir_valid <= 0 (wrong-path word discarded); ir/ir_pc still capture.
REQ-023 call: stack[sp] <= PC (return address = address after the call), sp <= sp+1, PC <= target, ir_valid <= 0.
REQ-024 ret: PC <= stack[sp-1], sp <= sp-1, ir_valid <= 0.
REQ-025 skip: PC <= PC+1, ir_valid <= 0.
REQ-026 Redirect latency: the first instruction at the new PC appears in ir with ir_valid=1 two edges after the redirect edge; exactly one bubble per redirect or skip.
REQ-027 Stack is circular: call with STACK_DEPTH entries occupied overwrites the oldest entry and sets stk_ovf.
REQ-028 ret with zero entries occupied sets stk_unf, PC takes the entry at the wrapped pointer, and sp wraps.
REQ-029 stk_ovf and stk_unf clear only on reset.
REQ-030 Control inputs during BOOT are ignored.

Reset
REQ-031 On rst_n=0, asynchronously: state=BOOT, PC=RESET_VECTOR, ir=14'h0000, ir_pc=11'h000, ir_valid=0, sp=0, stk_ovf=0, stk_unf=0; stack contents are not reset.
REQ-032 Reset asserted mid-operation, including during stall or redirect, overrides everything; the first fetch after release is from RESET_VECTOR.

Structure
REQ-033 Shared package fetch_pkg holds PC_W=11, INSTR_W=14, the FSM state enum (BOOT, RUN) and the default stack depth.
REQ-034 Sub-module return_stack holds the storage array, pointer, occupancy count and both sticky flags; the FSM, PC and IR remain in fetch_controller.

Verification
REQ-035 Reset release with a ROM model returning 14'h3E00|addr -> one BOOT cycle with ir_valid=0, then ir=14'h3E00, 14'h3E01, 14'h3E02 on consecutive edges with ir_pc = 0, 1, 2.
REQ-036 jump with target=11'h100 while ir_pc=3 -> next ir_valid=0, then ir_pc=11'h100 with ir_valid=1.
REQ-037 call with target=11'h200 while PC=11'h005, then ret at 11'h202 -> ir_pc sequence 11'h200, 11'h201, 11'h202, bubble, 11'h005; stk_ovf=0, stk_unf=0.
REQ-038 Nine nested calls followed by nine rets -> stk_ovf=1 after the ninth call; the ninth ret returns the eighth-pushed address and sets stk_unf=1.
REQ-039 stall held for 3 cycles, with jump asserted concurrently -> PC, ir, ir_valid unchanged and the jump ignored; sequential fetch resumes at PC+1 after stall drops.
REQ-040 PC at 11'h7FF with no redirect -> ir_pc=11'h7FF, then 11'h000; rst_n pulsed mid-call -> flags 0 and the fetch restarts at RESET_VECTOR.
